// File: rtl/reset_ctrl_pkg.sv
// Shared types and constants for the board reset sequencer (reset_ctrl).
package reset_ctrl_pkg;

    typedef enum logic [1:0] {
        CAUSE_POWER  = 2'd0,
        CAUSE_BUTTON = 2'd1,
        CAUSE_TRAP   = 2'd2
    } reset_cause_t;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RUN     = 2'd1,
        TRAPPED = 2'd2
    } state_t;

    localparam logic [3:0] TRAP_COUNT_MAX = 4'd15;

    function automatic logic [3:0] trap_count_inc(input logic [3:0] v);
        return (v == TRAP_COUNT_MAX) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/reset_ctrl_btn.sv
// Two-flop synchroniser plus debounce counter for the active-low reset button.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 12500
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_n,
    output logic pressed,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          deb_q, deb_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // deb_q is the accepted btn_n level: 1 = released
    always_comb begin
        deb_d   = deb_q;
        cnt_d   = '0;
        press_d = 1'b0;
        if (sync2_q != deb_q) begin
            if (cnt_q == CNT_LAST) begin
                deb_d   = sync2_q;
                press_d = ~sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            deb_q   <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= btn_n;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign pressed = ~deb_q;
    assign press   = press_q;

endmodule

// File: rtl/reset_ctrl.sv
// Board reset sequencer: debounced button, stretched resets, trap halt.
// Define RESET_CTRL_TRAP_RESTART_EN to auto-restart on trap instead of halting.
module reset_ctrl
    import reset_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 12500,
    parameter int STRETCH_CYCLES  = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_n,
    input  logic       trap,
    output logic       sys_reset,
    output logic       halted,
    output logic [1:0] reset_cause,
    output logic [3:0] trap_count
);

    localparam int SW = $clog2(STRETCH_CYCLES);
    localparam logic [SW-1:0] STRETCH_LAST = SW'(STRETCH_CYCLES - 1);

    logic btn_pressed, btn_press;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
        .clk    (clk),
        .reset  (reset),
        .btn_n  (btn_n),
        .pressed(btn_pressed),
        .press  (btn_press)
    );

    state_t       state_q, state_d;
    logic [SW-1:0] stretch_q, stretch_d;
    reset_cause_t cause_q, cause_d;
    logic         sys_reset_q, sys_reset_d;
    logic         halted_q, halted_d;
`ifdef RESET_CTRL_TRAP_RESTART_EN
    logic [3:0]   trap_count_q, trap_count_d;
`endif

    always_comb begin
        state_d   = state_q;
        stretch_d = stretch_q;
        cause_d   = cause_q;
`ifdef RESET_CTRL_TRAP_RESTART_EN
        trap_count_d = trap_count_q;
`endif
        case (state_q)
            HOLD: begin
                if (stretch_q != STRETCH_LAST) stretch_d = stretch_q + 1'b1;
                if (stretch_q == STRETCH_LAST && !btn_pressed) state_d = RUN;
            end
            RUN: begin
                // A press outranks a trap arriving in the same cycle
                if (btn_press) begin
                    state_d   = HOLD;
                    cause_d   = CAUSE_BUTTON;
                    stretch_d = '0;
                end else if (trap) begin
                    cause_d = CAUSE_TRAP;
`ifdef RESET_CTRL_TRAP_RESTART_EN
                    state_d      = HOLD;
                    stretch_d    = '0;
                    trap_count_d = trap_count_inc(trap_count_q);
`else
                    state_d = TRAPPED;
`endif
                end
            end
            TRAPPED: begin
                if (btn_press) begin
                    state_d   = HOLD;
                    cause_d   = CAUSE_BUTTON;
                    stretch_d = '0;
                end
            end
            default: state_d = HOLD;
        endcase
        sys_reset_d = (state_d != RUN);
        halted_d    = (state_d == TRAPPED);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= HOLD;
            stretch_q   <= '0;
            cause_q     <= CAUSE_POWER;
            sys_reset_q <= 1'b1;
            halted_q    <= 1'b0;
`ifdef RESET_CTRL_TRAP_RESTART_EN
            trap_count_q <= 4'd0;
`endif
        end else begin
            state_q     <= state_d;
            stretch_q   <= stretch_d;
            cause_q     <= cause_d;
            sys_reset_q <= sys_reset_d;
            halted_q    <= halted_d;
`ifdef RESET_CTRL_TRAP_RESTART_EN
            trap_count_q <= trap_count_d;
`endif
        end
    end

    assign sys_reset   = sys_reset_q;
    assign halted      = halted_q;
    assign reset_cause = cause_q;
`ifdef RESET_CTRL_TRAP_RESTART_EN
    assign trap_count  = trap_count_q;
`else
    assign trap_count  = 4'd0;
`endif

endmodule

// File: tb/tb_reset_ctrl.sv
// Self-checking bench for reset_ctrl with a cycle-level behavioural model.
module tb_reset_ctrl;

    localparam int DEB = 4;
    localparam int STR = 8;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       btn_n = 1'b1;
    logic       trap  = 1'b0;
    logic       sys_reset;
    logic       halted;
    logic [1:0] reset_cause;
    logic [3:0] trap_count;

    always #5 clk = ~clk;

    reset_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .STRETCH_CYCLES (STR)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_n      (btn_n),
        .trap       (trap),
        .sys_reset  (sys_reset),
        .halted     (halted),
        .reset_cause(reset_cause),
        .trap_count (trap_count)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: mode 0=held in reset, 1=running, 2=halted on trap
    bit m_valid = 1'b0;
    int m_mode, m_age, m_cause, m_count;
    bit m_deb, m_press;
    bit hist[$];

    initial forever begin
        @(posedge clk);
        if (reset) begin
            m_valid = 1'b1;
            m_mode  = 0;
            m_age   = 0;
            m_cause = 0;
            m_count = 0;
            m_deb   = 1'b1;
            m_press = 1'b0;
            hist.delete();
            for (int i = 0; i < 8; i++) hist.push_back(1'b1);
        end else if (m_valid) begin
            bit all_diff;
            case (m_mode)
                0: begin
                    if (m_age < STR) m_age++;
                    if (m_age >= STR && m_deb) m_mode = 1;
                end
                1: begin
                    if (m_press) begin
                        m_mode = 0; m_age = 0; m_cause = 1;
                    end else if (trap) begin
                        m_cause = 2;
`ifdef RESET_CTRL_TRAP_RESTART_EN
                        m_mode = 0; m_age = 0;
                        if (m_count < 15) m_count++;
`else
                        m_mode = 2;
`endif
                    end
                end
                default: begin
                    if (m_press) begin
                        m_mode = 0; m_age = 0; m_cause = 1;
                    end
                end
            endcase
            // accepted level flips once the pin (two cycles late) has differed DEB cycles running
            all_diff = 1'b1;
            for (int i = 1; i <= DEB; i++)
                if (hist[hist.size() - 1 - i] == m_deb) all_diff = 1'b0;
            m_press = 1'b0;
            if (all_diff) begin
                m_deb   = !m_deb;
                m_press = !m_deb;
            end
            hist.push_back(btn_n);
            if (hist.size() > 16) void'(hist.pop_front());
        end
    end

    initial forever begin
        @(negedge clk);
        if (m_valid) begin
            check("model_sys_reset", int'(sys_reset), int'(m_mode != 1));
            check("model_halted", int'(halted), int'(m_mode == 2));
            check("model_cause", int'(reset_cause), m_cause);
            check("model_trap_count", int'(trap_count), m_count);
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_sys_reset"}, int'(sys_reset), 1);
        check({tag, "_halted"}, int'(halted), 0);
        check({tag, "_cause"}, int'(reset_cause), 0);
        check({tag, "_trap_count"}, int'(trap_count), 0);
    endtask

    initial begin
        int tc_exp;
        // power-on: three reset cycles, then exactly eight cycles of sys_reset
        cycles(3);
        reset = 1'b0;
        check_reset_vals("po");
        for (int i = 1; i < STR; i++) begin
            cycles(1);
            check("po_stretch_hi", int'(sys_reset), 1);
        end
        cycles(1);
        check("po_stretch_lo", int'(sys_reset), 0);

        // 3-cycle glitch is shorter than the debounce window
        cycles(2);
        btn_n = 1'b0;
        cycles(3);
        btn_n = 1'b1;
        cycles(12);
        check("glitch_ignored", int'(sys_reset), 0);

        // long press: sys_reset rises 7 cycles after the pin edge
        btn_n = 1'b0;
        cycles(6);
        check("press_lat_lo", int'(sys_reset), 0);
        cycles(1);
        check("press_lat_hi", int'(sys_reset), 1);
        check("press_cause", int'(reset_cause), 1);
        cycles(13);
        btn_n = 1'b1;
        cycles(6);
        check("release_hold", int'(sys_reset), 1);
        cycles(1);
        check("release_run", int'(sys_reset), 0);
        check("release_cause", int'(reset_cause), 1);

        // trap pulse in RUN
        cycles(5);
        trap = 1'b1;
        cycles(1);
        trap = 1'b0;
`ifdef RESET_CTRL_TRAP_RESTART_EN
        check("trap_rst_hi", int'(sys_reset), 1);
        check("trap_halted", int'(halted), 0);
        check("trap_cause", int'(reset_cause), 2);
        check("trap_count1", int'(trap_count), 1);
        for (int i = 1; i < STR; i++) begin
            cycles(1);
            check("trap_stretch_hi", int'(sys_reset), 1);
        end
        cycles(1);
        check("trap_stretch_lo", int'(sys_reset), 0);
        for (int i = 0; i < 20; i++) begin
            cycles(19);
            trap = 1'b1;
            cycles(1);
            trap = 1'b0;
        end
        cycles(12);
        check("trap_count_sat", int'(trap_count), 15);
        tc_exp = 15;
`else
        check("trap_rst_hi", int'(sys_reset), 1);
        check("trap_halted", int'(halted), 1);
        check("trap_cause", int'(reset_cause), 2);
        cycles(100);
        check("trap_stay_rst", int'(sys_reset), 1);
        check("trap_stay_halted", int'(halted), 1);
        check("trap_stay_cause", int'(reset_cause), 2);
        btn_n = 1'b0;
        cycles(7);
        check("unhalt_rst", int'(sys_reset), 1);
        check("unhalt_halted", int'(halted), 0);
        check("unhalt_cause", int'(reset_cause), 1);
        btn_n = 1'b1;
        cycles(20);
        check("unhalt_run", int'(sys_reset), 0);
        check("unhalt_run_cause", int'(reset_cause), 1);
        tc_exp = 0;
`endif

        // press and trap reach the sequencer in the same cycle
        cycles(5);
        btn_n = 1'b0;
        cycles(6);
        trap = 1'b1;
        cycles(1);
        trap = 1'b0;
        check("simul_rst", int'(sys_reset), 1);
        check("simul_cause", int'(reset_cause), 1);
        check("simul_halted", int'(halted), 0);
        check("simul_trap_count", int'(trap_count), tc_exp);
        cycles(3);
        btn_n = 1'b1;
        cycles(20);
        check("simul_run", int'(sys_reset), 0);

        // reset while halted (or restarting)
        cycles(3);
        trap = 1'b1;
        cycles(1);
        trap = 1'b0;
        cycles(2);
        reset = 1'b1;
        cycles(1);
        check_reset_vals("mid_trap");
        reset = 1'b0;

        // reset in the middle of the power-on stretch
        cycles(3);
        reset = 1'b1;
        cycles(1);
        check_reset_vals("mid_stretch");
        reset = 1'b0;
        for (int i = 1; i < STR; i++) begin
            cycles(1);
            check("mid_stretch_hi", int'(sys_reset), 1);
        end
        cycles(1);
        check("mid_stretch_lo", int'(sys_reset), 0);

        // reset during a button-initiated hold
        cycles(3);
        btn_n = 1'b0;
        cycles(7);
        check("btn_hold_cause", int'(reset_cause), 1);
        reset = 1'b1;
        btn_n = 1'b1;
        cycles(1);
        check_reset_vals("mid_hold");
        reset = 1'b0;
        cycles(12);
        check("mid_hold_run", int'(sys_reset), 0);
        check("mid_hold_cause", int'(reset_cause), 0);

        cycles(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
